// File: rtl/demultiplexer_4way_pkg.sv
// Shared constants, slot state type and channel decode for the 4-way demultiplexer.
package demultiplexer_4way_pkg;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [SEL_W-1:0] CH0 = 2'd0;
  localparam logic [SEL_W-1:0] CH1 = 2'd1;
  localparam logic [SEL_W-1:0] CH2 = 2'd2;
  localparam logic [SEL_W-1:0] CH3 = 2'd3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Channel code to one-hot slot write enable.
  function automatic logic [N_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return N_CH'(1) << sel;
  endfunction

endpackage

// File: rtl/demultiplexer_4way_if.sv
// Producer/consumer bus of the 4-way demultiplexer.
//   ctrl, in_word, in_valid : producer word and destination channel
//   in_ready                : destination slot can accept (combinational)
//   out0..out3, out_valid   : registered slot data and full flags
//   out_ack                 : per-channel consumer take
//   last_sel, xfer_cnt      : last accepted channel, accepted-word count
interface demultiplexer_4way_if;
  import demultiplexer_4way_pkg::*;

  logic [SEL_W-1:0] ctrl;
  logic [WIDTH-1:0] in_word;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [N_CH-1:0]  out_valid;
  logic [N_CH-1:0]  out_ack;
  logic [SEL_W-1:0] last_sel;
  logic [CNT_W-1:0] xfer_cnt;

  modport master (
    output ctrl, in_word, in_valid, out_ack,
    input  in_ready, out0, out1, out2, out3, out_valid, last_sel, xfer_cnt
  );

  modport slave (
    input  ctrl, in_word, in_valid, out_ack,
    output in_ready, out0, out1, out2, out3, out_valid, last_sel, xfer_cnt
  );

endinterface

// File: rtl/demultiplexer_4way_demux_slot.sv
// One holding slot: data register plus EMPTY/FULL state.
//   clk, rst : clock, async active-high reset
//   wr, din  : load din this cycle (caller guarantees ready)
//   ack      : consumer takes the held word (ignored when empty)
//   dout     : held word, kept after ack
//   valid    : slot holds an unconsumed word
//   ready    : slot can take a word this cycle (combinational)
module demux_slot
  import demultiplexer_4way_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             ack,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             ready
);

  slot_state_e state;

  // State and data register; a write during ack keeps the slot full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SLOT_EMPTY;
      dout  <= '0;
    end else begin
      if (wr) dout <= din;
      case (state)
        SLOT_EMPTY: if (wr)         state <= SLOT_FULL;
        SLOT_FULL:  if (ack && !wr) state <= SLOT_EMPTY;
        default:                    state <= SLOT_EMPTY;
      endcase
    end
  end

  assign valid = (state == SLOT_FULL);
  // A draining slot can be refilled in the same cycle.
  assign ready = (state == SLOT_EMPTY) | ack;

endmodule

// File: rtl/demultiplexer_4way.sv
// Registered 1-to-4 demultiplexer with per-channel backpressure.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : producer/consumer interface (slave side)
module demultiplexer_4way
  import demultiplexer_4way_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  demultiplexer_4way_if.slave  bus
);

  logic [N_CH-1:0]  wr;
  logic [N_CH-1:0]  valid;
  logic [N_CH-1:0]  ready;
  logic [WIDTH-1:0] dout [N_CH];
  logic             accept;

  assign bus.in_ready = ready[bus.ctrl];
  assign accept       = bus.in_valid & ready[bus.ctrl];
  assign wr           = accept ? sel_onehot(bus.ctrl) : '0;

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_slot u_slot (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr[k]),
      .din   (bus.in_word),
      .ack   (bus.out_ack[k]),
      .dout  (dout[k]),
      .valid (valid[k]),
      .ready (ready[k])
    );
  end

  assign bus.out0      = dout[CH0];
  assign bus.out1      = dout[CH1];
  assign bus.out2      = dout[CH2];
  assign bus.out3      = dout[CH3];
  assign bus.out_valid = valid;

  // Last accepted channel and wrapping accept counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.last_sel <= '0;
      bus.xfer_cnt <= '0;
    end else if (accept) begin
      bus.last_sel <= bus.ctrl;
      bus.xfer_cnt <= bus.xfer_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demultiplexer_4way.sv
// Self-checking bench for demultiplexer_4way: directed cases plus randomized traffic
// against a slot-array model.
module tb_demultiplexer_4way;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   check_en;

  demultiplexer_4way_if bus ();

  demultiplexer_4way dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: four slots, each a word plus a full flag.
  logic [4:0] m_out [4];
  logic [3:0] m_valid;
  logic [1:0] m_last;
  logic [7:0] m_cnt;
  bit         last_accepted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("out0", 32'(bus.out0), 32'(m_out[0]));
      chk("out1", 32'(bus.out1), 32'(m_out[1]));
      chk("out2", 32'(bus.out2), 32'(m_out[2]));
      chk("out3", 32'(bus.out3), 32'(m_out[3]));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("last_sel", 32'(bus.last_sel), 32'(m_last));
      chk("xfer_cnt", 32'(bus.xfer_cnt), 32'(m_cnt));
      chk("in_ready", 32'(bus.in_ready),
          32'(!m_valid[bus.ctrl] || bus.out_ack[bus.ctrl]));
    end
  end

  // Drive one cycle of inputs (called at posedge+1), advance the model past the edge.
  task automatic cycle(input logic [1:0] c, input logic [4:0] d, input logic v,
                       input logic [3:0] a);
    logic [4:0] n_out [4];
    logic [3:0] n_valid;
    logic [1:0] n_last;
    logic [7:0] n_cnt;
    bit         rdy;
    bus.ctrl     = c;
    bus.in_word  = d;
    bus.in_valid = v;
    bus.out_ack  = a;
    n_out   = m_out;
    n_valid = m_valid & ~a;
    n_last  = m_last;
    n_cnt   = m_cnt;
    rdy = !m_valid[c] || a[c];
    last_accepted = v && rdy;
    if (last_accepted) begin
      n_out[c]   = d;
      n_valid[c] = 1'b1;
      n_last     = c;
      n_cnt      = m_cnt + 8'd1;
    end
    @(posedge clk);
    #1;
    m_out   = n_out;
    m_valid = n_valid;
    m_last  = n_last;
    m_cnt   = n_cnt;
  endtask

  // Mid-cycle reset assertion, immediate check, synchronous-looking release.
  task automatic do_reset();
    #3;
    bus.in_valid = 1'b0;
    bus.out_ack  = 4'b0000;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) m_out[k] = 5'd0;
    m_valid = 4'b0000;
    m_last  = 2'd0;
    m_cnt   = 8'd0;
    check_en = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out0", 32'(bus.out0), 32'h0);
    chk("rst_out3", 32'(bus.out3), 32'h0);
    chk("rst_xfer_cnt", 32'(bus.xfer_cnt), 32'h0);
    chk("rst_last_sel", 32'(bus.last_sel), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_accepted = 1'b1;
  endtask

  initial begin
    logic [1:0] c;
    logic [4:0] d;
    checks = 0;
    errors = 0;
    check_en = 1'b0;
    rst = 1'b0;
    bus.ctrl = 2'd0;
    bus.in_word = 5'd0;
    bus.in_valid = 1'b0;
    bus.out_ack = 4'b0000;
    @(posedge clk);
    #1;
    do_reset();

    // Basic route
    cycle(2'd2, 5'h15, 1'b1, 4'b0000);
    chk("route_out2", 32'(bus.out2), 32'h15);
    chk("route_valid", 32'(bus.out_valid), 32'h4);
    chk("route_last", 32'(bus.last_sel), 32'h2);
    chk("route_cnt", 32'(bus.xfer_cnt), 32'h1);

    // Backpressure on a full slot, then release by ack in the same cycle
    cycle(2'd1, 5'h07, 1'b1, 4'b0000);
    bus.ctrl = 2'd1; bus.in_word = 5'h0A; bus.in_valid = 1'b1; bus.out_ack = 4'b0000;
    #1;
    chk("bp_ready_low", 32'(bus.in_ready), 32'h0);
    cycle(2'd1, 5'h0A, 1'b1, 4'b0000);
    chk("bp_out1_held", 32'(bus.out1), 32'h07);
    chk("bp_cnt_held", 32'(bus.xfer_cnt), 32'h2);
    bus.out_ack = 4'b0010;
    #1;
    chk("bp_ready_ack", 32'(bus.in_ready), 32'h1);
    cycle(2'd1, 5'h0A, 1'b1, 4'b0010);
    chk("bp_out1_new", 32'(bus.out1), 32'h0A);
    chk("bp_valid1", 32'(bus.out_valid[1]), 32'h1);
    chk("bp_cnt", 32'(bus.xfer_cnt), 32'h3);

    // Fill all slots, then parallel drain
    for (int k = 0; k < 4; k++) cycle(2'(k), 5'(k + 1), 1'b1, 4'(1) << k);
    chk("fill_valid", 32'(bus.out_valid), 32'hF);
    cycle(2'd0, 5'd0, 1'b0, 4'b1111);
    chk("drain_valid", 32'(bus.out_valid), 32'h0);
    chk("drain_out0", 32'(bus.out0), 32'h01);
    chk("drain_out1", 32'(bus.out1), 32'h02);
    chk("drain_out2", 32'(bus.out2), 32'h03);
    chk("drain_out3", 32'(bus.out3), 32'h04);

    // Spurious ack on an empty slot
    cycle(2'd0, 5'd0, 1'b0, 4'b1000);
    chk("spur_valid", 32'(bus.out_valid), 32'h0);
    chk("spur_out3", 32'(bus.out3), 32'h04);

    // Counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cycle(2'(i % 4), 5'($urandom), 1'b1, 4'b1111);
      if (i == 254) chk("wrap_cnt_max", 32'(bus.xfer_cnt), 32'hFF);
    end
    chk("wrap_cnt", 32'(bus.xfer_cnt), 32'h0);
    chk("wrap_last", 32'(bus.last_sel), 32'h3);

    // Random traffic; producer holds a stalled word until accepted
    c = 2'd0;
    d = 5'd0;
    last_accepted = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (last_accepted || !bus.in_valid) begin
        c = 2'($urandom);
        d = 5'($urandom);
        cycle(c, d, 1'($urandom_range(0, 3) != 0), 4'($urandom) & 4'($urandom));
      end else begin
        cycle(c, d, 1'b1, 4'($urandom) & 4'($urandom));
      end
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
